// File: rtl/up_down_mod_counter_pkg.sv
// Purpose: shared types and modulo next-value arithmetic for up_down_mod_counter.
// Latency: n/a (types and a pure combinational function).
// Backpressure: none.
//
// mod_next works at a fixed internal width (UDC_MAX_W) so that any counter
// width up to UDC_MAX_W-1 bits can call it after zero-extending its operands.
package up_down_mod_counter_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

    localparam int UDC_MAX_W = 32;

    // Returns {wrap, next}. The modulus argument is one bit wider than the
    // count so that a full binary range (2**W) is representable.
    function automatic logic [UDC_MAX_W:0] mod_next(
        input logic [UDC_MAX_W-1:0] count,
        input logic [UDC_MAX_W-1:0] step,
        input dir_t                 dir,
        input logic [UDC_MAX_W:0]   modulus
    );
        logic [UDC_MAX_W:0]   sum;
        logic [UDC_MAX_W:0]   diff;
        logic [UDC_MAX_W-1:0] nxt;
        logic                 w;
        sum  = '0;
        diff = '0;
        nxt  = count;
        w    = 1'b0;
        if (dir == DIR_UP) begin
            sum = {1'b0, count} + {1'b0, step};
            if (sum >= modulus) begin
                diff = sum - modulus;
                nxt  = diff[UDC_MAX_W-1:0];
                w    = 1'b1;
            end else begin
                nxt = sum[UDC_MAX_W-1:0];
            end
        end else begin
            if (count < step) begin
                // Borrow: add the modulus back before subtracting.
                sum = {1'b0, count} + modulus - {1'b0, step};
                nxt = sum[UDC_MAX_W-1:0];
                w   = 1'b1;
            end else begin
                nxt = count - step;
            end
        end
        return {w, nxt};
    endfunction

endpackage

// File: rtl/up_down_mod_counter_next_calc.sv
// Purpose: combinational next count / wrap (and clamp when UDC_SATURATE_EN is defined).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
//
// Ports: count/step/up in, next/wrap/sat out; sat_mode in only with UDC_SATURATE_EN.
// sat is high when an update that would have wrapped was clamped instead.
module udc_next_calc
    import up_down_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic             up,
`ifdef UDC_SATURATE_EN
    input  logic             sat_mode,
`endif
    output logic [WIDTH-1:0] next,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [UDC_MAX_W:0] res;
    logic [WIDTH-1:0]   raw_next;
    logic               raw_wrap;
    logic               unused_hi;

    assign res      = mod_next(UDC_MAX_W'(count), UDC_MAX_W'(step), dir_t'(up),
                               (UDC_MAX_W+1)'(MODULUS));
    assign raw_next = res[WIDTH-1:0];
    assign raw_wrap = res[UDC_MAX_W];
    // Upper result bits are always zero because next < MODULUS <= 2**WIDTH.
    assign unused_hi = ^res[UDC_MAX_W-1:WIDTH];

    always_comb begin
        next = raw_next;
        wrap = raw_wrap;
        sat  = 1'b0;
`ifdef UDC_SATURATE_EN
        if (sat_mode && raw_wrap) begin
            next = up ? MAX_CNT : '0;
            wrap = 1'b0;
            sat  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/up_down_mod_counter.sv
// Purpose: parametrised up/down modulo counter with load, step, wrap/tc/ovf flags.
// Latency: count, wrap, ovf update on the edge that samples the inputs; tc is combinational.
// Backpressure: none; every enabled cycle advances the count.
//
// Optional feature macro: UDC_SATURATE_EN (adds sat_mode input after up).
// Ports: clk, clear (sync active-high), en, up, [sat_mode], step, load, load_value,
//        ovf_ack in; count, wrap, tc, ovf out.
// Edge priority: clear > load > en > hold.
module up_down_mod_counter
    import up_down_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
`ifdef UDC_SATURATE_EN
    input  logic             sat_mode,
`endif
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_ack,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] calc_next;
    logic             calc_wrap;
    logic             calc_sat;
    logic [WIDTH-1:0] load_clamped;
    logic             ovf_set;

    udc_next_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_calc (
        .count    (count),
        .step     (step),
        .up       (up),
`ifdef UDC_SATURATE_EN
        .sat_mode (sat_mode),
`endif
        .next     (calc_next),
        .wrap     (calc_wrap),
        .sat      (calc_sat)
    );

    // Out-of-range load values pin to the top of the range.
    assign load_clamped = ({1'b0, load_value} < MOD_W) ? load_value : MAX_CNT;

    // Only a real counting update can set ovf; a set beats a same-cycle ack.
    assign ovf_set = en && !load && (calc_wrap || calc_sat);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                count <= load_clamped;
                wrap  <= 1'b0;
            end else if (en) begin
                count <= calc_next;
                wrap  <= calc_wrap;
            end else begin
                wrap  <= 1'b0;
            end

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_ack) begin
                ovf <= 1'b0;
            end
        end
    end

    assign tc = up ? (count == MAX_CNT) : (count == '0);

    // Step values at or beyond the modulus have no defined result.
    a_step_legal : assert property (@(posedge clk) disable iff (clear)
        (en && !load) |-> ({1'b0, step} < MOD_W));

endmodule

// File: tb/tb_up_down_mod_counter.sv
module tb_up_down_mod_counter;

    logic       clk = 1'b0;
    logic       clear, en, up, load, ovf_ack;
    logic       sat_mode;
    logic [3:0] step, load_value;

    logic [3:0] count10, count16;
    logic       wrap10, wrap16, tc10, tc16, ovf10, ovf16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    up_down_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk        (clk),
        .clear      (clear),
        .en         (en),
        .up         (up),
`ifdef UDC_SATURATE_EN
        .sat_mode   (sat_mode),
`endif
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .ovf_ack    (ovf_ack),
        .count      (count10),
        .wrap       (wrap10),
        .tc         (tc10),
        .ovf        (ovf10)
    );

    up_down_mod_counter #(.WIDTH(4)) dut16 (
        .clk        (clk),
        .clear      (clear),
        .en         (en),
        .up         (up),
`ifdef UDC_SATURATE_EN
        .sat_mode   (sat_mode),
`endif
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .ovf_ack    (ovf_ack),
        .count      (count16),
        .wrap       (wrap16),
        .tc         (tc16),
        .ovf        (ovf16)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int c, input int w, input int o);
        chk({tag, ".count"}, int'(count10), c);
        chk({tag, ".wrap"},  int'(wrap10),  w);
        chk({tag, ".ovf"},   int'(ovf10),   o);
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; ovf_ack = 1'b0;
        sat_mode = 1'b0; step = 4'd0; load_value = 4'd0;

        // Reset state
        tick();
        chk3("reset", 0, 0, 0);
        chk("reset.tc_down", int'(tc10), 1);

        // Up count by 1 through a wrap
        clear = 1'b0; en = 1'b1; up = 1'b1; step = 4'd1;
        tick(); chk3("up1", 1, 0, 0);
        tick(); chk3("up2", 2, 0, 0);
        tick(); tick(); tick(); tick(); tick();
        chk3("up7", 7, 0, 0);
        tick(); chk3("up8", 8, 0, 0);
        tick(); chk3("up9", 9, 0, 0);
        chk("up9.tc", int'(tc10), 1);
        tick(); chk3("up_wrap", 0, 1, 1);
        tick(); chk3("up_after_wrap", 1, 0, 1);
        tick(); chk3("up12", 2, 0, 1);

        // Load 2 then count down by 3
        en = 1'b0; load = 1'b1; load_value = 4'd2;
        tick(); chk3("load2", 2, 0, 1);
        load = 1'b0; en = 1'b1; up = 1'b0; step = 4'd3;
        tick(); chk3("dn_wrap1", 9, 1, 1);
        tick(); chk3("dn6", 6, 0, 1);
        tick(); chk3("dn3", 3, 0, 1);
        tick(); chk3("dn0", 0, 0, 1);
        chk("dn0.tc", int'(tc10), 1);
        up = 1'b1; #1;
        chk("tc_dir_flip", int'(tc10), 0);
        up = 1'b0;
        tick(); chk3("dn_wrap2", 7, 1, 1);

        // Step 0 holds while enabled
        step = 4'd0;
        tick(); chk3("step0_hold", 7, 0, 1);

        // Out-of-range load with en: load wins, clamped to 9
        load = 1'b1; load_value = 4'd15; up = 1'b1; step = 4'd1;
        tick(); chk3("load_clamp", 9, 0, 1);
        chk("load_clamp.c16", int'(count16), 15);

        // Ack coincident with a wrap: ovf stays set; ack alone clears it
        load = 1'b0; ovf_ack = 1'b1;
        tick(); chk3("ack_vs_wrap", 0, 1, 1);
        chk("ack_vs_wrap.c16", int'(count16), 0);
        chk("ack_vs_wrap.w16", int'(wrap16), 1);
        tick(); chk3("ack_clears", 1, 0, 0);
        ovf_ack = 1'b0;

        // Hold after a wrap drops wrap; clear mid-count
        load = 1'b1; load_value = 4'd9;
        tick();
        load = 1'b0;
        tick(); chk3("rewrap", 0, 1, 1);
        en = 1'b0;
        tick(); chk3("hold", 0, 0, 1);
        load = 1'b1; load_value = 4'd6;
        tick(); chk3("load6", 6, 0, 1);
        load = 1'b0; en = 1'b1;
        tick(); chk3("cnt7", 7, 0, 1);
        clear = 1'b1;
        tick(); chk3("mid_clear", 0, 0, 0);
        clear = 1'b0;

`ifdef UDC_SATURATE_EN
        // Saturation clamps instead of wrapping, sets ovf, no wrap pulse
        sat_mode = 1'b1; en = 1'b0; load = 1'b1; load_value = 4'd8;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd3;
        tick(); chk3("sat_up", 9, 0, 1);
        en = 1'b0; load = 1'b1; load_value = 4'd1;
        tick();
        load = 1'b0; ovf_ack = 1'b1;
        tick(); chk3("sat_ack", 1, 0, 0);
        ovf_ack = 1'b0; en = 1'b1; up = 1'b0;
        tick(); chk3("sat_dn", 0, 0, 1);
        sat_mode = 1'b0; en = 1'b0;
`endif

        // Full binary rollover on the 16-wide instance
        clear = 1'b1;
        tick();
        clear = 1'b0; en = 1'b0; load = 1'b1; load_value = 4'd15; up = 1'b1;
        tick();
        chk("m16.load15", int'(count16), 15);
        chk("m16.tc", int'(tc16), 1);
        load = 1'b0; en = 1'b1; step = 4'd1;
        tick();
        chk("m16.roll.count", int'(count16), 0);
        chk("m16.roll.wrap",  int'(wrap16), 1);
        chk("m16.roll.ovf",   int'(ovf16), 1);
        en = 1'b0;
        tick();
        chk("m16.hold.wrap",  int'(wrap16), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
